// File: rtl/ram_banked_pkg.sv
// ram_banked_pkg: shared default sizes for the banked data RAM
package ram_banked_pkg;
  localparam int WORDSIZE      = 8;
  localparam int RAM_ADDR_SIZE = 5;
  localparam int RAM_BANK_BITS = 1;
endpackage

// File: rtl/ram_bank.sv
// ram_bank: one bank of storage with synchronous write and read-first registered read
module ram_bank #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ROW_BITS-1:0]  row,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout
);
  logic [WORD_SIZE-1:0] mem [2**ROW_BITS];
  // storage array kept free of reset so it maps onto RAM
  always_ff @(posedge clk)
    if (we) mem[row] <= din;
  // read register samples the old word, giving read-first on a same-row write
  always_ff @(posedge clk)
    if (rst) dout <= '0;
    else if (re) dout <= mem[row];
endmodule

// File: rtl/ram_banked.sv
// ram_banked: parametrised banked single-port RAM with clear sweep and registered read
module ram_banked
  import ram_banked_pkg::*;
#(
  parameter int WORD_SIZE = WORDSIZE,
  parameter int ADDR_SIZE = RAM_ADDR_SIZE,
  parameter int BANK_BITS = RAM_BANK_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 write_en,
  input  logic                 read_en,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy
);
  localparam int ROW_BITS = ADDR_SIZE - BANK_BITS;
  localparam int NBANKS   = 2**BANK_BITS;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  state_t                 state;
  logic [ROW_BITS-1:0]    cnt;
  logic [BANK_BITS-1:0]   bank_q;
  logic [BANK_BITS-1:0]   bank;
  logic [ROW_BITS-1:0]    row;
  logic                   clr, acc_rd, acc_wr;
  logic [WORD_SIZE-1:0]   bank_dout [NBANKS];
  assign bank     = addr[ADDR_SIZE-1 -: BANK_BITS];
  assign row      = addr[ROW_BITS-1:0];
  assign clr      = state == CLEAR && !rst;
  assign acc_rd   = state == IDLE && !rst && read_en;
  assign acc_wr   = state == IDLE && !rst && write_en;
  assign busy     = state == CLEAR;
  assign data_out = bank_dout[bank_q];
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    ram_bank #(.WORD_SIZE(WORD_SIZE), .ROW_BITS(ROW_BITS)) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (clr || (acc_wr && bank == BANK_BITS'(b))),
      .re   (acc_rd && bank == BANK_BITS'(b)),
      .row  (clr ? cnt : row),
      .din  (clr ? '0 : data_in),
      .dout (bank_dout[b])
    );
  end
  // clear sweep walks every row once, then hands over to normal access
  always_ff @(posedge clk)
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      bank_q     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= acc_rd;
      if (acc_rd) bank_q <= bank;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) state <= IDLE;
      end
    end
endmodule
